// File: rtl/dadda_mult_pipe.sv
// Pipelined WIDTH x WIDTH Dadda-tree multiplier, signed (Baugh-Wooley) or unsigned per operation.
// Operands are registered on acceptance; STAGES ranks follow, the last one driving y/out_valid.
module dadda_mult_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y
);

  localparam int NC   = 2 * WIDTH;
  localparam int MAXH = WIDTH + 1;
  localparam int NR   = STAGES - 1;
  localparam int NRA  = (NR > 0) ? NR : 1;

  function automatic int dadda_d(input int s);
    case (s)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      3:       return 6;
      4:       return 9;
      5:       return 13;
      6:       return 19;
      7:       return 28;
      default: return 42;
    endcase
  endfunction

  logic             op_v_q, op_s_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [NC-1:0]    tree_s, tree_c;

  logic             cs_v_q [NRA];
  logic [NC-1:0]    cs_s_q [NRA];
  logic [NC-1:0]    cs_c_q [NRA];
  logic             cs_v_d [NRA];
  logic [NC-1:0]    cs_s_d [NRA];
  logic [NC-1:0]    cs_c_d [NRA];

  logic             fin_v;
  logic [NC-1:0]    fin_s, fin_c, y_d;
  logic             out_valid_q;
  logic [NC-1:0]    y_q;

  // Global stall: every rank advances together whenever the output slot frees up.
  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign y         = y_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so each rank samples its predecessor's pre-edge value.
    if (rst) begin
      op_v_q <= 1'b0;
      op_s_q <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (in_ready) begin
      op_v_q <= in_valid;
      if (in_valid) begin
        op_s_q <= in_signed;
        op_a_q <= a;
        op_b_q <= b;
      end
    end
  end

  // Column-wise Dadda reduction: carries produced in column c count toward column c+1's height.
  always_comb begin : tree
    logic [MAXH-1:0] col  [NC];
    logic [MAXH-1:0] nxt  [NC];
    int              cnt  [NC];
    int              ncnt [NC];
    int              d, p;
    logic            x0, x1, x2, sm, cy;
    // NOTE: every variable gets a default first so no latch is inferred.
    d = 0; p = 0; x0 = 1'b0; x1 = 1'b0; x2 = 1'b0; sm = 1'b0; cy = 1'b0;
    tree_s = '0;
    tree_c = '0;
    for (int c = 0; c < NC; c++) begin
      col[c] = '0; nxt[c] = '0; cnt[c] = 0; ncnt[c] = 0;
    end

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        col[i+j][cnt[i+j]] = (op_a_q[i] & op_b_q[j]) ^
                             (op_s_q && ((i == WIDTH-1) != (j == WIDTH-1)));
        cnt[i+j]++;
      end
    end
    if (op_s_q) begin
      col[WIDTH][cnt[WIDTH]] = 1'b1;
      cnt[WIDTH]++;
      col[NC-1][cnt[NC-1]] = 1'b1;
      cnt[NC-1]++;
    end

    for (int s = 8; s >= 0; s--) begin
      d = dadda_d(s);
      for (int c = 0; c < NC; c++) begin
        nxt[c] = '0; ncnt[c] = 0;
      end
      for (int c = 0; c < NC; c++) begin
        p = 0;
        for (int k = 0; k < MAXH; k++) begin
          if (cnt[c] - p + ncnt[c] > d) begin
            x0 = col[c][p];
            x1 = col[c][p+1];
            if (cnt[c] - p + ncnt[c] == d + 1) begin
              sm = x0 ^ x1;
              cy = x0 & x1;
              p  = p + 2;
            end else begin
              x2 = col[c][p+2];
              sm = x0 ^ x1 ^ x2;
              cy = (x0 & x1) | (x2 & (x0 ^ x1));
              p  = p + 3;
            end
            nxt[c][ncnt[c]] = sm;
            ncnt[c]++;
            if (c < NC-1) begin
              nxt[c+1][ncnt[c+1]] = cy;
              ncnt[c+1]++;
            end
          end
        end
        for (int k = 0; k < MAXH; k++) begin
          if (k >= p && k < cnt[c]) begin
            nxt[c][ncnt[c]] = col[c][k];
            ncnt[c]++;
          end
        end
      end
      col = nxt;
      cnt = ncnt;
    end

    for (int c = 0; c < NC; c++) begin
      tree_s[c] = col[c][0];
      tree_c[c] = col[c][1];
    end
  end

  // Carry-save ranks hold the two reduced rows; the CPA sits in front of the output rank.
  always_comb begin
    for (int i = 0; i < NRA; i++) begin
      cs_v_d[i] = 1'b0; cs_s_d[i] = '0; cs_c_d[i] = '0;
    end
    cs_v_d[0] = op_v_q;
    cs_s_d[0] = tree_s;
    cs_c_d[0] = tree_c;
    for (int i = 1; i < NR; i++) begin
      cs_v_d[i] = cs_v_q[i-1];
      cs_s_d[i] = cs_s_q[i-1];
      cs_c_d[i] = cs_c_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NRA; i++) begin
        cs_v_q[i] <= 1'b0;
        cs_s_q[i] <= '0;
        cs_c_q[i] <= '0;
      end
    end else if (in_ready) begin
      for (int i = 0; i < NRA; i++) begin
        cs_v_q[i] <= cs_v_d[i];
        if (cs_v_d[i]) begin
          cs_s_q[i] <= cs_s_d[i];
          cs_c_q[i] <= cs_c_d[i];
        end
      end
    end
  end

  if (NR == 0) begin : g_direct
    assign fin_v = op_v_q;
    assign fin_s = tree_s;
    assign fin_c = tree_c;
  end else begin : g_ranked
    assign fin_v = cs_v_q[NR-1];
    assign fin_s = cs_s_q[NR-1];
    assign fin_c = cs_c_q[NR-1];
  end

  assign y_d = fin_s + fin_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else if (in_ready) begin
      out_valid_q <= fin_v;
      if (fin_v) y_q <= y_d;
    end
  end

endmodule
